// File: rtl/tff_toggle_sched.sv
// Command-driven pulse scheduler for a bank of T flip-flops: each accepted
// command toggles one flip-flop cnt times with gap idle cycles between toggles.
module tff_toggle_sched #(
  parameter int NUM_TFF = 8,
  parameter int CNT_W   = 4,
  parameter int GAP_W   = 2,
  localparam int IDX_W  = (NUM_TFF > 1) ? $clog2(NUM_TFF) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [IDX_W-1:0]   cmd_idx,
  input  logic [CNT_W-1:0]   cmd_cnt,
  input  logic [GAP_W-1:0]   cmd_gap,
  input  logic               abort,
  output logic [NUM_TFF-1:0] t_en,
  output logic [NUM_TFF-1:0] q,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx_q;
  logic [GAP_W-1:0]   gap_q;
  logic [CNT_W-1:0]   remaining;
  logic [GAP_W-1:0]   gap_cnt;
  logic [NUM_TFF-1:0] t_en_q;
  logic               cmd_bad;

  function automatic logic [NUM_TFF-1:0] onehot(input logic [IDX_W-1:0] i);
    return NUM_TFF'(1) << i;
  endfunction

  assign cmd_bad   = int'(cmd_idx) >= NUM_TFF;
  assign cmd_ready = (state == IDLE) && reset;

  // NOTE: t_en is registered, but abort must kill the toggle in the same cycle,
  // so the registered enable is masked combinationally; t_en_q is only nonzero
  // in PULSE, which is why abort has no visible effect in IDLE or DONE.
  assign t_en = t_en_q & {NUM_TFF{~abort}};

  always_ff @(posedge clk) begin
    // NOTE: every register here uses <=, so all branches see the pre-edge
    // values of state, remaining and gap_cnt regardless of statement order.
    if (!reset) begin
      state     <= IDLE;
      q         <= '0;
      t_en_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      idx_q     <= '0;
      gap_q     <= '0;
      remaining <= '0;
      gap_cnt   <= '0;
    end else begin
      q      <= q ^ t_en;
      t_en_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            idx_q     <= cmd_idx;
            gap_q     <= cmd_gap;
            remaining <= cmd_cnt;
            gap_cnt   <= '0;
            if (cmd_cnt == '0 || cmd_bad) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= cmd_bad;
            end else begin
              state  <= PULSE;
              busy   <= 1'b1;
              t_en_q <= onehot(cmd_idx);
            end
          end
        end
        PULSE: begin
          remaining <= remaining - CNT_W'(1);
          if (abort || remaining == CNT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (gap_q == '0) begin
            busy   <= 1'b1;
            t_en_q <= onehot(idx_q);
          end else begin
            state   <= GAP;
            busy    <= 1'b1;
            gap_cnt <= gap_q;
          end
        end
        GAP: begin
          if (abort) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            busy    <= 1'b1;
            gap_cnt <= gap_cnt - GAP_W'(1);
            // gap_cnt was loaded with gap, so the last idle cycle sees 1
            if (gap_cnt == GAP_W'(1)) begin
              state  <= PULSE;
              t_en_q <= onehot(idx_q);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
